life_scheduler: RTL and testbench
=================================

# life_scheduler

Generation scheduler and memory-port arbiter for the Life core. It uses the VGA timing counters to launch one update-engine generation per N frames, or per single-step request. It double-buffers the cell memory by swapping the display/update buffer select only at the start of vertical blanking. It also shares the single cell-memory port between the display pixel fetch (strict priority) and the update engine.

## Interface
Parameters:
- DISPLAY_WIDTH, 640, active pixels per line
- DISPLAY_HEIGHT, 480, active lines per frame
- GEN_W, 16, generation counter width

Ports:
- vclk_in  in  1  pixel clock
- rst_in  in  1  reset; asynchronous, active-high
- hcount_in  in  11  pixel number from timing generator
- vcount_in  in  10  line number from timing generator
- run_in  in  1  level: free-run generations
- step_in  in  1  one-cycle pulse: request one generation
- speed_in  in  4  frames per generation minus one (0 = every frame)
- upd_done_in  in  1  one-cycle pulse from update engine: generation written
- disp_req_in  in  1  display fetch wants memory port
- upd_req_in  in  1  update engine wants memory port
- upd_start_out  out  1  one-cycle pulse: begin generation
- grant_disp_out  out  1  display owns port this cycle
- grant_upd_out  out  1  update engine owns port this cycle
- disp_sel_out  out  1  buffer shown; update reads disp_sel_out, writes ~disp_sel_out
- gen_count_out  out  GEN_W  completed (swapped) generations
- busy_out  out  1  generation in flight or awaiting swap
- overrun_out  out  1  sticky: a generation missed a frame tick

## Operation
- frame_tick: internal, high for exactly one cycle when vcount_in == DISPLAY_HEIGHT and hcount_in == 0, which is the first vblank cycle.
- Frame divider: frame_cnt (4 bit) increments on each frame_tick. rate_hit = run_in & (frame_cnt >= speed_in). frame_cnt clears to 0 on every frame_tick where a trigger is taken.
- step_pend: set by step_in. Cleared when consumed. A step_in arriving while step_pend is already set is absorbed.
- trigger = rate_hit | step_pend, sampled only on frame_tick.
- FSM states:
  - IDLE: on frame_tick & trigger, go to START.
  - START: upd_start_out = 1 for one cycle; go to COMPUTE.
  - COMPUTE: on upd_done_in, go to READY. On frame_tick while still in COMPUTE, set overrun_out and stay.
  - READY: on frame_tick, toggle disp_sel_out and increment gen_count_out (wraps modulo 2^GEN_W). Go to START if trigger, else IDLE.
- Simultaneous upd_done_in and frame_tick in COMPUTE:
  - Done wins and goes to READY; overrun is not set.
  - The swap waits for the next frame_tick.
- Frame tick vs. trigger consumption:
  - A step_in coincident with frame_tick counts for that tick.
  - step_pend is consumed by the transition IDLE→START or READY→START.
- busy_out = state != IDLE.
- Arbiter, registered:
  - grant_disp_out <= disp_req_in.
  - grant_upd_out <= upd_req_in & ~disp_req_in & (state == COMPUTE).
  - Requesters hold req until granted.
  - Grants are never high together.
- upd_done_in outside COMPUTE is ignored.
- Reset, including mid-generation: all state returns to reset values immediately. The update engine shares rst_in.

## Timing
- Reset values:
  - state = IDLE; frame_cnt = 0; step_pend = 0.
  - upd_start_out, grant_disp_out, grant_upd_out = 0.
  - disp_sel_out = 0; gen_count_out = 0; busy_out = 0; overrun_out = 0.
- upd_start_out: one cycle after the frame_tick cycle.
- Grants: one cycle after the request.
- disp_sel_out toggle: visible the cycle after frame_tick, inside vblank, so no tearing.
- Minimum generation period is one frame. Back-to-back generations (speed_in = 0) swap and restart on the same tick.
- All outputs are registered.

## Structure
- Package life_pkg holds:
  - sched_state_t enum {IDLE, START, COMPUTE, READY}
  - DISPLAY_WIDTH and DISPLAY_HEIGHT defaults, shared with the timing generator
  - GEN_W
- One sub-module: life_frame_div, containing frame_tick detection, frame_cnt and rate_hit.
- FSM and arbiter stay in life_scheduler.

## Test plan
- Free-run:
  - Stimulus: run_in = 1, speed_in = 0, engine returns done 1000 cycles after start.
  - Required response: upd_start_out once per frame; disp_sel_out toggles every frame; gen_count_out = 5 after 6 frame ticks.
- Speed divide:
  - Stimulus: run_in = 1, speed_in = 3.
  - Required response: upd_start_out every 4th frame_tick; gen_count_out = 2 after 12 ticks.
- Step:
  - Stimulus: run_in = 0, one step_in mid-frame.
  - Required response: exactly one upd_start_out at the next tick; swap one frame later; then IDLE, busy_out = 0. A second step_in before the tick still yields one generation.
- Overrun:
  - Stimulus: done delayed past the next frame_tick.
  - Required response: overrun_out = 1 and stays 1; swap occurs at the first tick after done.
- Arbitration:
  - Stimulus: disp_req_in and upd_req_in high together in COMPUTE.
  - Required response: only grant_disp_out = 1. With disp_req_in dropped, grant_upd_out = 1 the next cycle. In IDLE, grant_upd_out stays 0.
- Reset mid-COMPUTE:
  - Stimulus: assert rst_in asynchronously.
  - Required response: all outputs at reset values before the next clock edge; disp_sel_out = 0; gen_count_out = 0.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and display constants for the Life core.
// Imported by the scheduler, the frame divider and the timing generator.
package life_pkg;

    localparam int DISPLAY_WIDTH  = 640;
    localparam int DISPLAY_HEIGHT = 480;
    localparam int GEN_W          = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        COMPUTE = 2'd2,
        READY   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/life_frame_div.sv
// Frame tick detection and frames-per-generation divider.
// frame_tick marks the first cycle of vertical blanking.
module life_frame_div #(
    parameter int DISPLAY_HEIGHT = life_pkg::DISPLAY_HEIGHT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        run,
    input  logic [3:0]  speed,
    input  logic        take,
    output logic        frame_tick,
    output logic        rate_hit
);

    logic [3:0] frame_cnt;

    assign frame_tick = (vcount == 10'(DISPLAY_HEIGHT)) && (hcount == '0);
    assign rate_hit   = run & (frame_cnt >= speed);

    // Count frames since the last taken trigger; restart when one is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 4'd0;
        end else if (frame_tick) begin
            if (take)
                frame_cnt <= 4'd0;
            else
                frame_cnt <= frame_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/life_scheduler.sv
// Generation scheduler, buffer swap and cell-memory port arbiter.
// Swaps display/update buffers only at the start of vertical blanking.
module life_scheduler import life_pkg::*; #(
    parameter int DISPLAY_WIDTH  = life_pkg::DISPLAY_WIDTH,
    parameter int DISPLAY_HEIGHT = life_pkg::DISPLAY_HEIGHT,
    parameter int GEN_W          = life_pkg::GEN_W
) (
    input  logic             vclk_in,
    input  logic             rst_in,
    input  logic [10:0]      hcount_in,
    input  logic [9:0]       vcount_in,
    input  logic             run_in,
    input  logic             step_in,
    input  logic [3:0]       speed_in,
    input  logic             upd_done_in,
    input  logic             disp_req_in,
    input  logic             upd_req_in,
    output logic             upd_start_out,
    output logic             grant_disp_out,
    output logic             grant_upd_out,
    output logic             disp_sel_out,
    output logic [GEN_W-1:0] gen_count_out,
    output logic             busy_out,
    output logic             overrun_out
);

    if (DISPLAY_WIDTH > 2048 || DISPLAY_HEIGHT > 1023) begin : g_range
        $error("display size exceeds timing counter width");
    end

    sched_state_t state;
    logic         frame_tick;
    logic         rate_hit;
    logic         step_pend;
    logic         trigger;
    logic         take;

    // A step arriving on the tick itself counts for that tick.
    assign trigger = rate_hit | step_pend | step_in;
    assign take    = frame_tick & trigger
                   & ((state == IDLE) | (state == READY));

    life_frame_div #(
        .DISPLAY_HEIGHT (DISPLAY_HEIGHT)
    ) u_frame_div (
        .clk        (vclk_in),
        .rst        (rst_in),
        .hcount     (hcount_in),
        .vcount     (vcount_in),
        .run        (run_in),
        .speed      (speed_in),
        .take       (take),
        .frame_tick (frame_tick),
        .rate_hit   (rate_hit)
    );

    // Remember a single-step request until a generation launch consumes it.
    always_ff @(posedge vclk_in or posedge rst_in) begin
        if (rst_in)
            step_pend <= 1'b0;
        else if (take)
            step_pend <= 1'b0;
        else if (step_in)
            step_pend <= 1'b1;
    end

    // Generation FSM with registered start pulse, swap and status outputs.
    always_ff @(posedge vclk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= IDLE;
            upd_start_out <= 1'b0;
            disp_sel_out  <= 1'b0;
            gen_count_out <= '0;
            busy_out      <= 1'b0;
            overrun_out   <= 1'b0;
        end else begin
            upd_start_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (take) begin
                        state         <= START;
                        upd_start_out <= 1'b1;
                        busy_out      <= 1'b1;
                    end
                end
                START: begin
                    state <= COMPUTE;
                end
                COMPUTE: begin
                    if (upd_done_in)
                        state <= READY;
                    else if (frame_tick)
                        overrun_out <= 1'b1;
                end
                READY: begin
                    if (frame_tick) begin
                        disp_sel_out  <= ~disp_sel_out;
                        gen_count_out <= gen_count_out + GEN_W'(1);
                        if (trigger) begin
                            state         <= START;
                            upd_start_out <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            busy_out <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Display fetch has strict priority; update only owns the port mid-generation.
    always_ff @(posedge vclk_in or posedge rst_in) begin
        if (rst_in) begin
            grant_disp_out <= 1'b0;
            grant_upd_out  <= 1'b0;
        end else begin
            grant_disp_out <= disp_req_in;
            grant_upd_out  <= upd_req_in & ~disp_req_in & (state == COMPUTE);
        end
    end

endmodule

// File: tb/tb_life_scheduler.sv
// Randomized bench for life_scheduler against a frame-level model.
// Uses a shrunken raster so many frames fit in a short run.
module tb_life_scheduler;

    localparam int DW = 16;
    localparam int DH = 8;
    localparam int HT = 20;
    localparam int VT = 10;
    localparam int GW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [10:0]   hc;
    logic [9:0]    vc;
    logic          run;
    logic          step;
    logic [3:0]    speed;
    logic          done;
    logic          dreq;
    logic          ureq;
    logic          start;
    logic          gd;
    logic          gu;
    logic          sel;
    logic [GW-1:0] gen;
    logic          busy;
    logic          ovr;

    int checks = 0;
    int errors = 0;

    // model of the spec: phase 0 idle, 1 start, 2 compute, 3 ready
    int ph;
    int fcnt;
    bit pend;
    bit m_start;
    bit m_gd;
    bit m_gu;
    bit m_sel;
    int m_gen;
    bit m_ovr;

    int nticks;
    int nstarts;
    int lat;
    int dcount;
    bit rnd_req;
    bit rnd_lat;

    always #5 clk = ~clk;

    life_scheduler #(
        .DISPLAY_WIDTH  (DW),
        .DISPLAY_HEIGHT (DH),
        .GEN_W          (GW)
    ) dut (
        .vclk_in        (clk),
        .rst_in         (rst),
        .hcount_in      (hc),
        .vcount_in      (vc),
        .run_in         (run),
        .step_in        (step),
        .speed_in       (speed),
        .upd_done_in    (done),
        .disp_req_in    (dreq),
        .upd_req_in     (ureq),
        .upd_start_out  (start),
        .grant_disp_out (gd),
        .grant_upd_out  (gu),
        .disp_sel_out   (sel),
        .gen_count_out  (gen),
        .busy_out       (busy),
        .overrun_out    (ovr)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit ft;
        bit tr;
        bit launch;
        ft = (vc == 10'(DH)) && (hc == 11'd0);
        tr = (run && fcnt >= int'(speed)) || pend || step;
        launch = 1'b0;
        m_start = 1'b0;
        m_gd = dreq;
        m_gu = ureq && !dreq && ph == 2;
        if (ft) nticks++;
        if (ph == 0) begin
            if (ft && tr) launch = 1'b1;
        end else if (ph == 1) begin
            ph = 2;
        end else if (ph == 2) begin
            if (done) ph = 3;
            else if (ft) m_ovr = 1'b1;
        end else begin
            if (ft) begin
                m_sel = !m_sel;
                m_gen = (m_gen + 1) % 65536;
                if (tr) launch = 1'b1;
                else ph = 0;
            end
        end
        if (ft) fcnt = launch ? 0 : (fcnt + 1) % 16;
        pend = launch ? 1'b0 : (pend || step);
        if (launch) begin
            ph = 1;
            m_start = 1'b1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("start", start, m_start);
        chk("grant_disp", gd, m_gd);
        chk("grant_upd", gu, m_gu);
        chk("disp_sel", sel, m_sel);
        chk("gen_count", gen, m_gen);
        chk("busy", busy, ph != 0);
        chk("overrun", ovr, m_ovr);
        if (start) nstarts++;
        done = 1'b0;
        if (dcount > 0) begin
            dcount--;
            if (dcount == 0) done = 1'b1;
        end
        if (start) begin
            if (rnd_lat) lat = $urandom_range(20, 300);
            dcount = lat;
        end
        step = 1'b0;
        if (rnd_req) begin
            dreq = 1'($urandom_range(0, 1));
            ureq = 1'($urandom_range(0, 1));
        end
        if (hc == 11'(HT - 1)) begin
            hc = 11'd0;
            vc = (vc == 10'(VT - 1)) ? 10'd0 : vc + 10'd1;
        end else begin
            hc = hc + 11'd1;
        end
    endtask

    task automatic frames(int n);
        int t0;
        int lim;
        t0 = nticks;
        lim = n * HT * VT + HT * VT;
        while (nticks < t0 + n && lim > 0) begin
            cyc();
            lim--;
        end
        if (lim == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_wait got %0d exp %0d", nticks, t0 + n);
        end
        repeat (2) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hc = 11'd0;
        vc = 10'd0;
        run = 1'b0;
        step = 1'b0;
        speed = 4'd0;
        done = 1'b0;
        dreq = 1'b0;
        ureq = 1'b0;
        ph = 0;
        fcnt = 0;
        pend = 1'b0;
        m_start = 1'b0;
        m_gd = 1'b0;
        m_gu = 1'b0;
        m_sel = 1'b0;
        m_gen = 0;
        m_ovr = 1'b0;
        nticks = 0;
        nstarts = 0;
        dcount = 0;
        rnd_lat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start", start, 0);
        chk("rst_gd", gd, 0);
        chk("rst_gu", gu, 0);
        chk("rst_sel", sel, 0);
        chk("rst_gen", gen, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", ovr, 0);
        rst = 1'b0;
    endtask

    initial begin
        rnd_req = 1'b1;
        lat = 100;

        // free-run, one generation per frame
        do_reset();
        run = 1'b1;
        speed = 4'd0;
        lat = 100;
        frames(6);
        chk("free_gen", gen, 5);
        chk("free_starts", nstarts, 6);
        chk("free_sel", sel, 1);

        // divide by four
        do_reset();
        run = 1'b1;
        speed = 4'd3;
        lat = 100;
        frames(12);
        chk("div_gen", gen, 2);
        chk("div_starts", nstarts, 3);

        // single step with a second absorbed request
        do_reset();
        lat = 100;
        repeat (50) cyc();
        step = 1'b1;
        cyc();
        repeat (20) cyc();
        step = 1'b1;
        cyc();
        frames(3);
        chk("step_starts", nstarts, 1);
        chk("step_gen", gen, 1);
        chk("step_busy", busy, 0);

        // done arrives after the next tick
        do_reset();
        run = 1'b1;
        lat = 250;
        frames(3);
        chk("ovr_flag", ovr, 1);
        chk("ovr_gen", gen, 1);
        frames(2);
        chk("ovr_sticky", ovr, 1);

        // directed arbitration
        do_reset();
        rnd_req = 1'b0;
        lat = 1000;
        step = 1'b1;
        cyc();
        frames(1);
        repeat (3) cyc();
        dreq = 1'b1;
        ureq = 1'b1;
        cyc();
        chk("arb_both_gd", gd, 1);
        chk("arb_both_gu", gu, 0);
        dreq = 1'b0;
        cyc();
        chk("arb_upd_gu", gu, 1);
        chk("arb_upd_gd", gd, 0);

        // asynchronous reset mid-generation
        chk("pre_rst_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_gu", gu, 0);
        chk("arst_sel", sel, 0);
        chk("arst_gen", gen, 0);
        do_reset();

        // no update grant while idle
        ureq = 1'b1;
        dreq = 1'b0;
        repeat (3) cyc();
        chk("idle_gu", gu, 0);

        // random steps, run toggles, speeds and latencies
        do_reset();
        rnd_req = 1'b1;
        rnd_lat = 1'b1;
        speed = 4'($urandom_range(0, 3));
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) step = 1'b1;
            if ($urandom_range(0, 499) == 0) run = !run;
            if ($urandom_range(0, 999) == 0) speed = 4'($urandom_range(0, 3));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
